// File: rtl/if_id_buffer.sv
// IF/ID pipeline register for the 16-bit core: write-enable stall, read-enable output gating.
// Optional synchronous bubble insert via FLUSH when IF_ID_BUFFER_FLUSH_EN is defined.
module if_id_buffer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             READ_ENABLE,
  input  logic             WRITE_ENABLE,
  input  logic [WIDTH-1:0] PROGRAM_COUNTER,
  input  logic [WIDTH-1:0] INSTRUCTION,
`ifdef IF_ID_BUFFER_FLUSH_EN
  input  logic             FLUSH,
`endif
  output logic [WIDTH-1:0] PROGRAM_COUNTER_OUT,
  output logic [WIDTH-1:0] INSTRUCTION_OUT,
  output logic             VALID_OUT
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] instr_d;
  logic             valid_q;
  logic             valid_d;

  // Next-state selection: flush (if built) beats write, otherwise hold for a stall.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
`ifdef IF_ID_BUFFER_FLUSH_EN
    if (FLUSH) begin
      pc_d    = {WIDTH{1'b0}};
      instr_d = {WIDTH{1'b0}};
      valid_d = 1'b0;
    end else if (WRITE_ENABLE) begin
      pc_d    = PROGRAM_COUNTER;
      instr_d = INSTRUCTION;
      valid_d = 1'b1;
    end else begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end
`else
    if (WRITE_ENABLE) begin
      pc_d    = PROGRAM_COUNTER;
      instr_d = INSTRUCTION;
      valid_d = 1'b1;
    end else begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end
`endif
  end

  // Storage register with asynchronous clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q    <= {WIDTH{1'b0}};
      instr_q <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Combinational read gating; decode sees zeros when reads are disabled.
  always_comb begin
    PROGRAM_COUNTER_OUT = {WIDTH{1'b0}};
    INSTRUCTION_OUT     = {WIDTH{1'b0}};
    VALID_OUT           = 1'b0;
    if (READ_ENABLE) begin
      PROGRAM_COUNTER_OUT = pc_q;
      INSTRUCTION_OUT     = instr_q;
      VALID_OUT           = valid_q;
    end else begin
      PROGRAM_COUNTER_OUT = {WIDTH{1'b0}};
      INSTRUCTION_OUT     = {WIDTH{1'b0}};
      VALID_OUT           = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed test-plan scenarios plus randomized traffic
// compared against a behavioural model of the stored entry.
module tb_if_id_buffer;

  localparam int WIDTH = 16;

  logic             CLK;
  logic             RST;
  logic             READ_ENABLE;
  logic             WRITE_ENABLE;
  logic [WIDTH-1:0] PROGRAM_COUNTER;
  logic [WIDTH-1:0] INSTRUCTION;
  logic             FLUSH;
  logic [WIDTH-1:0] PROGRAM_COUNTER_OUT;
  logic [WIDTH-1:0] INSTRUCTION_OUT;
  logic             VALID_OUT;

  int checks_cnt;
  int fail_cnt;

  // Reference model: the entry the decode stage would see if reads were enabled.
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_instr;
  logic             m_valid;

  if_id_buffer #(.WIDTH(WIDTH)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .READ_ENABLE         (READ_ENABLE),
    .WRITE_ENABLE        (WRITE_ENABLE),
    .PROGRAM_COUNTER     (PROGRAM_COUNTER),
    .INSTRUCTION         (INSTRUCTION),
`ifdef IF_ID_BUFFER_FLUSH_EN
    .FLUSH               (FLUSH),
`endif
    .PROGRAM_COUNTER_OUT (PROGRAM_COUNTER_OUT),
    .INSTRUCTION_OUT     (INSTRUCTION_OUT),
    .VALID_OUT           (VALID_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [WIDTH-1:0] e_pc;
    logic [WIDTH-1:0] e_in;
    logic             e_v;
    e_pc = READ_ENABLE ? m_pc    : 16'h0000;
    e_in = READ_ENABLE ? m_instr : 16'h0000;
    e_v  = READ_ENABLE ? m_valid : 1'b0;
    check_value({tag, ".pc"},    {16'h0000, PROGRAM_COUNTER_OUT}, {16'h0000, e_pc});
    check_value({tag, ".instr"}, {16'h0000, INSTRUCTION_OUT},     {16'h0000, e_in});
    check_value({tag, ".valid"}, {31'h0, VALID_OUT},              {31'h0, e_v});
  endtask

  function automatic bit flush_active();
`ifdef IF_ID_BUFFER_FLUSH_EN
    return FLUSH == 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One rising edge: apply the update rule to the model, then sample 1 time unit later.
  task automatic tick(input string tag);
    @(posedge CLK);
    if (RST !== 1'b1) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_valid = 1'b0;
    end else if (flush_active()) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_valid = 1'b0;
    end else if (WRITE_ENABLE == 1'b1) begin
      m_pc = PROGRAM_COUNTER; m_instr = INSTRUCTION; m_valid = 1'b1;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic assert_reset(input string tag);
    #2;
    RST = 1'b0;
    m_pc = 16'h0000; m_instr = 16'h0000; m_valid = 1'b0;
    #1;
    check_outputs(tag);
  endtask

  task automatic set_inputs(input logic we, input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] ins);
    WRITE_ENABLE = we; PROGRAM_COUNTER = pc; INSTRUCTION = ins;
  endtask

  initial begin
    checks_cnt = 0; fail_cnt = 0;
    m_pc = 16'h0000; m_instr = 16'h0000; m_valid = 1'b0;
    RST = 1'b0; READ_ENABLE = 1'b1; FLUSH = 1'b0;
    set_inputs(1'b0, 16'h0000, 16'h0000);
    #3;
    check_outputs("reset");
    tick("reset_edge");
    #2 RST = 1'b1;

    // Basic capture
    set_inputs(1'b1, 16'h0002, 16'hFFFF);
    tick("cap1");
    set_inputs(1'b1, 16'h0004, 16'hFFF2);
    tick("cap2");

    // Asynchronous reset mid-run, edges while low, X on enables ignored
    assert_reset("async_rst");
    WRITE_ENABLE = 1'bx; READ_ENABLE = 1'b1;
    tick("rst_hold1");
    WRITE_ENABLE = 1'b1;
    tick("rst_hold2");
    #2 RST = 1'b1;

    // Stall
    set_inputs(1'b0, 16'h0008, 16'hFFF4);
    tick("stall0");
    set_inputs(1'b1, 16'h000A, 16'hFFF5);
    tick("stall_cap");
    set_inputs(1'b0, 16'h0000, 16'h0000);
    tick("stall1");
    tick("stall2");

    // Read gating without clock edges
    #2 READ_ENABLE = 1'b0;
    #1 check_outputs("read_off");
    READ_ENABLE = 1'b1;
    #1 check_outputs("read_on");
    check_value("read_on.direct_pc", {16'h0000, PROGRAM_COUNTER_OUT}, 32'h0000_000A);

`ifdef IF_ID_BUFFER_FLUSH_EN
    set_inputs(1'b1, 16'h000C, 16'h1234);
    FLUSH = 1'b1;
    tick("flush");
    FLUSH = 1'b0;
    tick("post_flush");
`endif

    // Randomized traffic with occasional mid-cycle asynchronous reset
    for (int i = 0; i < 400; i++) begin
      set_inputs(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 9) == 0) PROGRAM_COUNTER = 16'hFFFF;
      if ($urandom_range(0, 9) == 0) INSTRUCTION = 16'h0000;
      READ_ENABLE = 1'($urandom_range(0, 4) != 0);
      FLUSH = 1'($urandom_range(0, 7) == 0);
      tick("rand");
      if ($urandom_range(0, 29) == 0) begin
        assert_reset("rand_rst");
        tick("rand_rst_edge");
        #2 RST = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
